fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC and drives the F->D pipeline register.
//  Per cycle it produces instr / pc8 / delay-slot flag / exccode for the D register.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_addr_check.sv | 17 +
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_LIMIT = 32'h0000_6FFC;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StRun   = 2'd1,
      StFault = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address legality: word aligned and inside the instruction memory window.
module fetch_addr_check
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
   input  logic [31:0] pc,
   output logic        legal
);

   // Unsigned window compare plus alignment
   always_comb begin
      legal = (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc <= IM_LIMIT);
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, applies redirects/stalls, flags fetch address errors
// and drives the F->D pipeline register inputs.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        is_jb_d,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc8_o,
   output logic        bd_o,
   output logic [4:0]  exccode_o
);

   logic [31:0]  pc_q, pc_d;
   fetch_state_e state_q, state_d;
   logic         legal;

   fetch_addr_check #(
      .IM_BASE  (IM_BASE),
      .IM_LIMIT (IM_LIMIT)
   ) u_addr_check (
      .pc    (pc_q),
      .legal (legal)
   );

   // PC and FSM state registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pc_q    <= RESET_PC;
         state_q <= StBoot;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   // Next-PC / next-state: exc_req > eret > boot > stall > fault > AdEL > branch > +4
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (exc_req) begin
         pc_d    = EXC_PC;
         state_d = StRun;
      end else if (eret) begin
         pc_d    = epc;
         state_d = StRun;
      end else if (state_q == StBoot) begin
         state_d = StRun;
      end else if (stall || state_q == StFault) begin
         // hold
      end else if (!legal) begin
         // Park on the faulting PC; a branch resolved this cycle is dropped
         state_d = StFault;
      end else if (br_taken) begin
         pc_d = br_target;
      end else begin
         pc_d = pc_q + 32'd4;
      end
   end

   // F outputs: bubble unless running with no redirect in flight
   always_comb begin
      instr_o   = 32'd0;
      exccode_o = EXC_NONE;
      bd_o      = 1'b0;
      if (state_q == StRun && !exc_req && !eret) begin
         bd_o = is_jb_d;
         if (legal) begin
            instr_o = imem_rdata;
         end else begin
            exccode_o = EXC_ADEL;
         end
      end
   end

   assign pc_o      = pc_q;
   assign imem_addr = pc_q;
   assign pc8_o     = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected F outputs are pushed when a cycle's
// stimulus is driven and popped/compared at the following falling edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        clr_n = 1'b1;
   logic        stall, br_taken, is_jb_d, exc_req, eret;
   logic [31:0] br_target, epc;
   logic [31:0] imem_addr, imem_rdata, pc_o, instr_o, pc8_o;
   logic        bd_o;
   logic [4:0]  exccode_o;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic        bd;
      logic [4:0]  exccode;
   } obs_t;

   obs_t        sb[$];
   obs_t        got, want;
   int unsigned vecs = 0;
   int unsigned miscmp = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .is_jb_d    (is_jb_d),
      .exc_req    (exc_req),
      .eret       (eret),
      .epc        (epc),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .pc_o       (pc_o),
      .instr_o    (instr_o),
      .pc8_o      (pc8_o),
      .bd_o       (bd_o),
      .exccode_o  (exccode_o)
   );

   // Instruction memory contents are a fixed function of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   function automatic logic legal_ref(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
   endfunction

   function automatic obs_t exp_run(input logic [31:0] pc, input logic bd);
      obs_t o;
      o.pc      = pc;
      o.addr    = pc;
      o.pc8     = pc + 32'd8;
      o.bd      = bd;
      o.instr   = legal_ref(pc) ? mem_word(pc) : 32'd0;
      o.exccode = legal_ref(pc) ? 5'd0 : 5'd4;
      return o;
   endfunction

   function automatic obs_t exp_bub(input logic [31:0] pc);
      obs_t o;
      o.pc      = pc;
      o.addr    = pc;
      o.pc8     = pc + 32'd8;
      o.bd      = 1'b0;
      o.instr   = 32'd0;
      o.exccode = 5'd0;
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.pc      = pc_o;
      o.addr    = imem_addr;
      o.instr   = instr_o;
      o.pc8     = pc8_o;
      o.bd      = bd_o;
      o.exccode = exccode_o;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("pc=%h addr=%h instr=%h pc8=%h bd=%b exc=%0d",
                       o.pc, o.addr, o.instr, o.pc8, o.bd, o.exccode);
   endfunction

   task automatic drive(input logic st, input logic bt, input logic [31:0] tgt,
                        input logic jb, input logic ex, input logic er,
                        input logic [31:0] ep);
      stall     = st;
      br_taken  = bt;
      br_target = tgt;
      is_jb_d   = jb;
      exc_req   = ex;
      eret      = er;
      epc       = ep;
   endtask

   task automatic test_reset();
      drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
      #1 clr_n = 1'b0;
      #1;
      sb.push_back(exp_bub(32'h3000));
      got = observe(); want = sb.pop_front(); vecs++;
      if (got !== want) begin
         miscmp++;
         $display("FAIL reset_values: got %s required %s", fmt(got), fmt(want));
      end
      @(negedge clk);
      clr_n = 1'b1;
      #1;
      sb.push_back(exp_bub(32'h3000));
      got = observe(); want = sb.pop_front(); vecs++;
      if (got !== want) begin
         miscmp++;
         $display("FAIL boot_bubble: got %s required %s", fmt(got), fmt(want));
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
         sb.push_back(exp_run(32'h3000 + 32'(4 * i), 1'b0));
         @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL seq_fetch[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h300C, 0)); end
            1: begin drive(0, 1, 32'h3100, 1, 0, 0, 32'h0); sb.push_back(exp_run(32'h3010, 1)); end
            default: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3100, 0)); end
         endcase
         @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL branch[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin drive(0, 1, 32'h3020, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3104, 0)); end
            1, 2, 3: begin
               drive(1, 1, 32'h3100, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3020, 0));
            end
            4: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3020, 0)); end
            default: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3024, 0)); end
         endcase
         @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL stall[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_adel();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin drive(0, 1, 32'h3002, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3028, 0)); end
            // Misaligned PC: AdEL flagged, concurrent branch must be ignored
            1: begin drive(0, 1, 32'h3100, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3002, 0)); end
            2: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_bub(32'h3002)); end
            3: begin drive(0, 1, 32'h3100, 1, 0, 0, 32'h0); sb.push_back(exp_bub(32'h3002)); end
            4: begin drive(0, 0, 32'h0, 0, 1, 0, 32'h0); sb.push_back(exp_bub(32'h3002)); end
            default: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h4180, 0)); end
         endcase
         @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL adel[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect_priority();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin drive(0, 1, 32'h3040, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h4184, 0)); end
            1: begin drive(1, 1, 32'h3100, 1, 1, 1, 32'h3044); sb.push_back(exp_bub(32'h3040)); end
            2: begin drive(0, 0, 32'h0, 1, 0, 1, 32'h3044); sb.push_back(exp_bub(32'h4180)); end
            default: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3044, 0)); end
         endcase
         @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL redirect[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 9; i++) begin
         case (i)
            0: begin drive(0, 1, 32'h3ABC, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3048, 0)); end
            1: begin drive(0, 1, 32'h3100, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3ABC, 0)); end
            // Reset asserted between edges, then held across a rising edge
            2: begin #2 clr_n = 1'b0; #1 sb.push_back(exp_bub(32'h3000)); end
            3: sb.push_back(exp_bub(32'h3000));
            4: begin clr_n = 1'b1; drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_bub(32'h3000)); end
            5: begin drive(0, 1, 32'h6FFC, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h3000, 0)); end
            6: begin drive(0, 0, 32'h0, 0, 0, 0, 32'h0); sb.push_back(exp_run(32'h6FFC, 0)); end
            7: sb.push_back(exp_run(32'h7000, 0));
            default: begin drive(0, 0, 32'h0, 0, 0, 1, 32'h3000); sb.push_back(exp_bub(32'h7000)); end
         endcase
         if (i != 2) @(negedge clk);
         got = observe(); want = sb.pop_front(); vecs++;
         if (got !== want) begin
            miscmp++;
            $display("FAIL async_reset[%0d]: got %s required %s", i, fmt(got), fmt(want));
         end
         if (i != 1) begin
            @(posedge clk); #1;
         end
      end
      drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
      sb.push_back(exp_run(32'h3000, 0));
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vecs++;
      if (got !== want) begin
         miscmp++;
         $display("FAIL fault_exit: got %s required %s", fmt(got), fmt(want));
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall();
      test_adel();
      test_redirect_priority();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
